fir_interp_x2_tx: RTL and testbench



---
 rtl/fir_interp_pkg.sv | 46 ++++
 rtl/fir_interp_x2_tx_sat_round_q15.sv | 49 ++++
 rtl/fir_interp_x2_tx.sv | 108 ++++++++++
 tb/tb_fir_interp_x2_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_interp_pkg.sv
// Shared definitions for the x2 polyphase interpolator and its output stage.
// Holds sample/fraction widths, round/saturate constants, the FSM state enum
// and the three 16-entry coefficient ROMs (h[0..15], even index = phase 0).
package fir_interp_pkg;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned COEF_FRAC = 15;
    localparam int unsigned ROM_DEPTH = 16;
    localparam int unsigned ROM_AW    = 4;

    localparam int ROUND_CONST = 1 << (COEF_FRAC - 1);
    localparam int SAT_MAX     = 32767;
    localparam int SAT_MIN     = -32768;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC0,
        S_OUT0,
        S_MAC1,
        S_OUT1
    } state_t;

    typedef logic signed [15:0] coef_rom_t [ROM_DEPTH];

    // Symmetric 16-tap 20 kHz low-pass; each phase sums to 32768 (unity per phase).
    localparam coef_rom_t COEF_LPF_20K = '{
        -16'sd176, -16'sd456, -16'sd412,  16'sd617,
         16'sd2910, 16'sd6583, 16'sd10551, 16'sd13151,
         16'sd13151, 16'sd10551, 16'sd6583, 16'sd2910,
         16'sd617, -16'sd412, -16'sd456, -16'sd176
    };

    localparam coef_rom_t COEF_FLAT  = '{default: 16'sd4096};
    localparam coef_rom_t COEF_GAIN2 = '{default: 16'sd8192};

    // ROM lookup: sel 1 = flat, 2 = gain-2, anything else = production LPF.
    function automatic logic signed [15:0] coef_at(input int unsigned sel,
                                                   input logic [ROM_AW-1:0] idx);
        case (sel)
            1:       coef_at = COEF_FLAT[idx];
            2:       coef_at = COEF_GAIN2[idx];
            default: coef_at = COEF_LPF_20K[idx];
        endcase
    endfunction

endpackage

// File: rtl/fir_interp_x2_tx_sat_round_q15.sv
// Registered round-half-up and saturate from a wide Q15 accumulator to 16 bits.
// Ports: clk, rst (sync, active-high), en (capture strobe), acc (accumulator),
//        data (rounded/saturated sample, held between strobes), valid (1-cycle pulse).
module sat_round_q15
    import fir_interp_pkg::*;
#(
    parameter int unsigned ACC_W = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] data,
    output logic                       valid
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned SHR_W = SUM_W - COEF_FRAC;

    logic signed [SUM_W-1:0]    rounded;
    logic signed [SHR_W-1:0]    shifted;
    logic signed [SAMPLE_W-1:0] sat_val;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        rounded = SUM_W'(acc) + SUM_W'(ROUND_CONST);
        shifted = SHR_W'(rounded >>> COEF_FRAC);
        if (shifted > SHR_W'(SAT_MAX)) begin
            sat_val = SAMPLE_W'(SAT_MAX);
        end else if (shifted < SHR_W'(SAT_MIN)) begin
            sat_val = SAMPLE_W'(SAT_MIN);
        end else begin
            sat_val = shifted[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                data <= sat_val;
            end
        end
    end

endmodule

// File: rtl/fir_interp_x2_tx.sv
// x2 polyphase FIR interpolator for the TX path, one shared multiply-accumulate.
// Each accepted sample produces two outputs: y0 (even taps) then y1 (odd taps).
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready (input handshake),
//        out_data/out_valid (rounded, saturated output with 1-cycle strobe).
module fir_interp_x2_tx
    import fir_interp_pkg::*;
#(
    parameter int unsigned TAPS_PER_PHASE = 8,
    parameter int unsigned COEF_W         = 16,
    parameter int unsigned COEF_SET       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic                       out_valid
);

    localparam int unsigned P      = TAPS_PER_PHASE;
    localparam int unsigned CNT_W  = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned PROD_W = SAMPLE_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(P);

    state_t                     state;
    logic [CNT_W-1:0]           tap;
    logic signed [SAMPLE_W-1:0] dline [P];
    logic signed [ACC_W-1:0]    acc;
    logic signed [COEF_W-1:0]   coef;
    logic signed [SAMPLE_W-1:0] tap_x;
    logic signed [PROD_W-1:0]   prod;
    logic                       phase;
    logic                       accept;
    logic                       last_tap;
    logic                       out_en;

    // Ready only in IDLE and never while reset is asserted.
    assign in_ready = (state == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign phase    = (state == S_MAC1);
    assign last_tap = (tap == CNT_W'(P - 1));
    assign out_en   = (state == S_OUT0) || (state == S_OUT1);

    // Coefficient index 2k+phase is simply {k, phase}.
    always_comb begin
        coef  = COEF_W'(coef_at(COEF_SET, ROM_AW'({tap, phase})));
        tap_x = dline[tap];
        prod  = PROD_W'(coef) * PROD_W'(tap_x);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            tap   <= '0;
            acc   <= '0;
            for (int i = 0; i < int'(P); i++) begin
                dline[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dline[0] <= in_data;
                        for (int i = 1; i < int'(P); i++) begin
                            dline[i] <= dline[i-1];
                        end
                        acc   <= '0;
                        tap   <= '0;
                        state <= S_MAC0;
                    end
                end
                S_MAC0, S_MAC1: begin
                    acc <= acc + ACC_W'(prod);
                    if (last_tap) begin
                        tap   <= '0;
                        state <= (state == S_MAC0) ? S_OUT0 : S_OUT1;
                    end else begin
                        tap <= tap + CNT_W'(1);
                    end
                end
                S_OUT0: begin
                    acc   <= '0;
                    state <= S_MAC1;
                end
                S_OUT1: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output stage samples acc during OUT0/OUT1, before the clear lands.
    sat_round_q15 #(
        .ACC_W (ACC_W)
    ) u_sat_round (
        .clk   (clk),
        .rst   (rst),
        .en    (out_en),
        .acc   (acc),
        .data  (out_data),
        .valid (out_valid)
    );

endmodule

// File: tb/tb_fir_interp_x2_tx.sv
// Bench for fir_interp_x2_tx: all three coefficient sets run in lockstep on the
// same stimulus; a dot-product reference model predicts every output and its edge.
`timescale 1ns/1ps
module tb_fir_interp_x2_tx;

    localparam int P    = 8;
    localparam int NDUT = 3;
    localparam int GAP  = 2*P + 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [15:0]   in_data;
    logic                 in_valid;
    logic [NDUT-1:0]      in_ready;
    logic signed [15:0]   out_data [NDUT];
    logic [NDUT-1:0]      out_valid;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fir_interp_x2_tx #(
            .TAPS_PER_PHASE (P),
            .COEF_W         (16),
            .COEF_SET       (g)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g])
        );
    end

    typedef struct { int val; int edge_no; } exp_t;
    typedef struct { int din; int exp1; int exp2; bit check; } vec_t;

    exp_t expq [NDUT][$];
    int   seen [NDUT][$];
    int   hist [P];
    int   lpf [16] = '{-176, -456, -412, 617, 2910, 6583, 10551, 13151,
                       13151, 10551, 6583, 2910, 617, -412, -456, -176};
    int   edges      = 0;
    int   ready_from = 0;
    int   last_acc   = -1;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   last_out [NDUT];
    bit   prev_v [NDUT];
    vec_t vecs [$];

    task automatic chk(input string name, input int d, input longint got, input longint req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (edge %0d)", name, d, got, req, edges);
        end
    endtask

    task automatic note_fail(input string name, input int d);
        n_cmp++;
        n_bad++;
        $display("FAIL %s dut%0d at edge %0d", name, d, edges);
    endtask

    function automatic int clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int coef(input int s, input int i);
        if (s == 1) return 4096;
        if (s == 2) return 8192;
        return lpf[i];
    endfunction

    // Reference: full dot product per phase, round half up, clamp.
    function automatic int model_y(input int s, input int p);
        longint sum = 0;
        for (int k = 0; k < P; k++) begin
            sum += longint'(coef(s, 2*k + p)) * longint'(hist[k]);
        end
        return clamp16((sum + 64'sd16384) >>> 15);
    endfunction

    task automatic send(input int s, input bit hold, input bit check_gap, output int acc_edge);
        int   waited = 0;
        exp_t e;
        acc_edge = -1;
        @(negedge clk);
        while (!in_ready[0] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[0]) begin
            note_fail("ready_timeout", 0);
            return;
        end
        in_data  = 16'(s);
        in_valid = 1'b1;
        acc_edge = edges + 1;
        if (check_gap && last_acc >= 0) chk("accept_spacing", 0, acc_edge - last_acc, GAP);
        last_acc = acc_edge;
        for (int k = P-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        for (int d = 0; d < NDUT; d++) begin
            e.val = model_y(d, 0); e.edge_no = acc_edge + P + 1;   expq[d].push_back(e);
            e.val = model_y(d, 1); e.edge_no = acc_edge + 2*P + 2; expq[d].push_back(e);
        end
        ready_from = acc_edge + 2*P + 2;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (!in_ready[0] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[0]) note_fail("idle_timeout", 0);
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        for (int d = 0; d < NDUT; d++) seen[d].delete();
        send(v.din, 1'b0, 1'b0, a);
        wait_idle();
        chk("strobes_per_sample", 1, seen[1].size(), 2);
        chk("strobes_per_sample", 2, seen[2].size(), 2);
        if (v.check && seen[1].size() == 2 && seen[2].size() == 2) begin
            chk("tbl_y0", 1, seen[1][0], v.exp1);
            chk("tbl_y1", 1, seen[1][1], v.exp1);
            chk("tbl_y0", 2, seen[2][0], v.exp2);
            chk("tbl_y1", 2, seen[2][1], v.exp2);
        end
    endtask

    task automatic add_block(input int val, input int len);
        vec_t v;
        for (int r = 1; r <= len; r++) begin
            v.din   = val;
            v.exp1  = clamp16(val);
            v.exp2  = clamp16(2 * longint'(val));
            v.check = (r >= P);
            vecs.push_back(v);
        end
    endtask

    // Output monitor: reset effects, in_ready, strobe values/timing, hold behaviour.
    initial begin : monitor
        exp_t e;
        bit   rst_e;
        forever begin
            @(posedge clk);
            edges++;
            rst_e = rst;
            #1;
            if (rst_e) begin
                for (int k = 0; k < P; k++) hist[k] = 0;
                ready_from = edges;
                for (int d = 0; d < NDUT; d++) begin
                    expq[d].delete();
                    chk("reset_out_valid", d, out_valid[d], 0);
                    chk("reset_out_data", d, out_data[d], 0);
                    chk("reset_in_ready", d, in_ready[d], 0);
                    last_out[d] = 0;
                    prev_v[d]   = 1'b0;
                end
            end else begin
                for (int d = 0; d < NDUT; d++) begin
                    chk("in_ready", d, in_ready[d], (edges >= ready_from) ? 1 : 0);
                    if (out_valid[d]) begin
                        chk("valid_back_to_back", d, prev_v[d], 0);
                        if (expq[d].size() == 0) begin
                            note_fail("unexpected_strobe", d);
                        end else begin
                            e = expq[d].pop_front();
                            chk("y_value", d, out_data[d], e.val);
                            chk("y_edge", d, edges, e.edge_no);
                        end
                        seen[d].push_back(int'(out_data[d]));
                        last_out[d] = out_data[d];
                    end else begin
                        chk("hold", d, out_data[d], last_out[d]);
                    end
                    prev_v[d] = out_valid[d];
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: bench did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t v;
        int   a;
        int   s;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Impulse: eight pairs of 4096 (flat) / 8192 (gain-2), then zeros.
        for (int n = 0; n < 10; n++) begin
            v.din   = (n == 0) ? 32767 : 0;
            v.exp1  = (n < P) ? 4096 : 0;
            v.exp2  = (n < P) ? 8192 : 0;
            v.check = 1'b1;
            vecs.push_back(v);
        end
        add_block(8000, 20);
        add_block(-8000, 20);
        add_block(20000, 12);
        add_block(-20000, 12);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Continuous in_valid: one acceptance every 2P+3 cycles.
        for (int i = 0; i < 12; i++) begin
            s = int'($urandom_range(0, 65535)) - 32768;
            send(s, 1'b1, i > 0, a);
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset during MAC1 after filling the delay line with non-zero data.
        for (int n = 0; n < P; n++) begin
            send(9000, 1'b0, 1'b0, a);
            wait_idle();
        end
        send(32767, 1'b0, 1'b0, a);
        while (edges < a + P + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Tones at 1 kHz and 40 kHz (100 kS/s input rate).
        for (int n = 0; n < 60; n++) begin
            s = $rtoi(30000.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 100.0));
            send(s, 1'b0, 1'b0, a);
        end
        for (int n = 0; n < 40; n++) begin
            s = $rtoi(30000.0 * $sin(2.0 * 3.14159265358979 * 0.4 * real'(n)));
            send(s, 1'b0, 1'b0, a);
        end

        // Full-scale random samples with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            s = int'($urandom_range(0, 65535)) - 32768;
            send(s, 1'b0, 1'b0, a);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        for (int d = 0; d < NDUT; d++) chk("pending_outputs", d, expq[d].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
